dmem_lsu_rv32i: RTL
===================

// Module: dmem_lsu_rv32i
// PURPOSE
//  Parametrised RV32I data memory with a load/store unit front end, the successor to the fixed 256-word SPRAM.
//  Accepts one request per cycle over a valid/ready handshake and writes with byte enables.
//  Returns sign- or zero-extended load data one cycle after accept, and flags misaligned or out-of-range accesses.
//  Sits between the core's execute stage and the writeback mux.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; power of two, >=2; AW = $clog2(DEPTH_WORDS)
//  INIT_FILE    ""   hex file loaded with $readmemh at time 0 when non-empty; contents otherwise X
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept; transfer when req_valid & req_ready
//  req_we      in   1   1 = store, 0 = load
//  req_size    in   2   00 = byte, 01 = half, 10 = word, 11 = reserved (error)
//  req_unsigned in  1   loads: 1 = zero-extend (LBU/LHU), 0 = sign-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified (rs2)
//  rsp_valid   out  1   one-cycle pulse per accepted request
//  rsp_rdata   out  32  extended load data; 0 for stores and errors
//  rsp_err     out  1   valid with rsp_valid: misaligned, out of range, or size 11
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, req_ready=0 while rst is high, then 1. Memory is not cleared.
//  Word index = addr[AW+1:2]; byte offset = addr[1:0]. Out of range if addr[31:AW+2] != 0.
//  Aligned path, accept at edge T:
//   - Store: bytes written at edge T via byte enables (B: 1 lane by offset; H: 0011 or 1100; W: 1111).
//   - Load: word read at edge T; offset, size and unsigned are registered.
//   - Response at T+1: rsp_valid=1; rdata shifted right by 8*offset, then sign- or zero-extended from bit 7 or 15.
//  Back-to-back: a request is accepted every cycle in IDLE. A load at T+1 to the word stored at T returns the new data.
//  Error (size 11, out of range, or misaligned without the split feature):
//   - No write occurs.
//   - rsp_valid=1, rsp_err=1, rsp_rdata=0 at T+1.
//  Misaligned: H with addr[0]=1; W with addr[1:0] != 0.
//  FSM states: IDLE, SPLIT2. Only IDLE exists when the split feature is compiled out.
//   - IDLE -> SPLIT2 on accepting a word-crossing access, which requires split enabled: H at offset 3, or W at offset 1..3.
//   - SPLIT2 -> IDLE after one cycle, which accesses word N+1; the response is issued at T+2.
//   - req_ready=0 in SPLIT2.
//  The range check covers both N and N+1 at accept; N = DEPTH_WORDS-1 crossing gives an error (no wrap, no write).
//  Reset mid-SPLIT2: abandon the access; the first-half store bytes stay written; no response is issued.
//  rsp_valid is never backpressured; the consumer must take it.
// CONFIGURATION
//  DMEM_MISALIGN_SPLIT_EN defined:
//   - Misaligned accesses that stay inside one word (H at offset 1) complete on the aligned path with byte lanes 0110.
//   - Word-crossing accesses use SPLIT2.
//     Store: low bytes go to word N at T, high bytes to word N+1 at T+1.
//     Load: bytes are read from N and N+1, concatenated, and extended.
//  Undefined: all misaligned accesses give an error response. SPLIT2 logic is not built; req_ready = !rst.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp at T+1: rdata=0xDEADBEEF, err=0.
//  2. SB 0x80 @0x13, then LB and LBU @0x13 -> 0xFFFFFF80 and 0x00000080; the other bytes of word 4 are unchanged.
//  3. SH 0x1234 @0x22, then LH @0x22 -> 0x00001234; LW @0x20 -> 0x1234xxxx (upper half).
//  4. LW @0x11 (split off) -> err=1, rdata=0; memory unchanged. LW @(DEPTH_WORDS*4) -> err=1.
//  5. Split on: SW 0xAABBCCDD @0x21 -> req_ready low 1 cycle; LW @0x21 -> 0xAABBCCDD at T+2; word 0x24 byte0 = 0xAA.
//  6. Assert rst during SPLIT2 -> rsp_valid stays 0, req_ready=0 until rst drops, outputs 0; next request behaves normally.

Source files
------------

// File: rtl/dmem_lsu_rv32i.sv
// RV32I data memory with load/store unit front end: byte-enable stores, extended loads, error flagging.
// Define DMEM_MISALIGN_SPLIT_EN to service misaligned accesses (word-crossing ones via a second cycle).
//
// state  | meaning
// IDLE   | accepting one request per cycle
// SPLIT2 | second half of a word-crossing access, touches word N+1 (split build only)
module dmem_lsu_rv32i #(
  parameter int DEPTH_WORDS = 256,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          out_of_range;
  logic          misaligned;
  logic          req_err;
  logic          split_start;
  logic          in_split;
  logic          accept;
  logic [3:0]    mask4;
  logic [3:0]    be_lo;
  logic [31:0]   wd_lo;

  assign idx          = req_addr[AW+1:2];
  assign off          = req_addr[1:0];
  assign out_of_range = (req_addr >> (AW + 2)) != 32'd0;
  assign misaligned   = ((req_size == SZ_H) && off[0]) ||
                        ((req_size == SZ_W) && (off != 2'b00));
  assign req_ready    = !rst && !in_split;
  assign accept       = req_valid && req_ready;

  always_comb begin
    mask4 = 4'b1111;
    case (req_size)
      SZ_B:    mask4 = 4'b0001;
      SZ_H:    mask4 = 4'b0011;
      default: mask4 = 4'b1111;
    endcase
  end

  // Lanes/data landing in word N; for crossings the spill-over goes to N+1
  assign be_lo = mask4 << off;
  assign wd_lo = req_wdata << {off, 3'b000};

  logic [AW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wd;
  logic          rd_en;
  logic [31:0]   rd_q;

`ifdef DMEM_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE, SPLIT2} state_t;

  state_t        state_q, state_d;
  logic          crossing;
  logic          last_word;
  logic [3:0]    be_hi;
  logic [31:0]   wd_hi;
  logic [AW-1:0] idx_hi_q;
  logic [3:0]    be_hi_q;
  logic [31:0]   wd_hi_q;
  logic [31:0]   lo_q;
  logic          rsp_split_q;

  assign crossing    = ((req_size == SZ_H) && (off == 2'b11)) ||
                       ((req_size == SZ_W) && (off != 2'b00));
  assign last_word   = idx == AW'(DEPTH_WORDS - 1);
  assign req_err     = (req_size == 2'b11) || out_of_range || (crossing && last_word);
  assign split_start = crossing && !req_err;
  assign in_split    = state_q == SPLIT2;
  assign be_hi       = 4'(({4'b0000, mask4} << off) >> 4);
  assign wd_hi       = 32'(({32'd0, req_wdata} << {off, 3'b000}) >> 32);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && split_start) state_d = SPLIT2;
      SPLIT2:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && split_start) begin
      idx_hi_q <= idx + 1'b1;
      be_hi_q  <= req_we ? be_hi : 4'b0000;
      wd_hi_q  <= wd_hi;
    end
    if (in_split) lo_q <= rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rsp_split_q <= 1'b0;
    else if (accept) rsp_split_q <= split_start;
  end
`else
  assign req_err     = (req_size == 2'b11) || out_of_range || misaligned;
  assign split_start = 1'b0;
  assign in_split    = 1'b0;
`endif

  always_comb begin
    mem_idx = idx;
    mem_be  = (accept && req_we && !req_err) ? be_lo : 4'b0000;
    mem_wd  = wd_lo;
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (in_split) begin
      mem_idx = idx_hi_q;
      mem_be  = be_hi_q;
      mem_wd  = wd_hi_q;
    end
`endif
  end

  assign rd_en = accept || in_split;

  // Read-before-write on the same edge; a load one cycle later sees the store
  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem[mem_idx];
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  logic       load_q;
  logic [1:0] off_q;
  logic [1:0] size_q;
  logic       uns_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      load_q    <= 1'b0;
      off_q     <= 2'b00;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
    end else begin
      rsp_valid <= (accept && !split_start) || in_split;
      rsp_err   <= accept && req_err;
      if (accept) begin
        load_q <= !req_we && !req_err;
        off_q  <= off;
        size_q <= req_size;
        uns_q  <= req_unsigned;
      end
    end
  end

  logic [31:0] sh;
  logic [31:0] ext;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [63:0] pair;
  assign pair = rsp_split_q ? {rd_q, lo_q} : {32'd0, rd_q};
  assign sh   = 32'(pair >> {off_q, 3'b000});
`else
  assign sh   = rd_q >> {off_q, 3'b000};
`endif

  always_comb begin
    ext = sh;
    case (size_q)
      SZ_B:    ext = uns_q ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    ext = uns_q ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  assign rsp_rdata = (rsp_valid && load_q) ? ext : 32'd0;

endmodule
